fault_campaign_ctrl: RTL and testbench

Sequential fault-injection campaign controller that sits directly upstream of the adder built from PGA cells and drives its `fault_en_bus`/`fault_val` inputs plus its operand inputs. For every gate ID and both stuck-at values it applies an exhaustive operand sweep. It compares the faulty adder's result against an internally computed golden sum and reports one mismatch count per (gate, stuck value) pair over a valid/ready stream. One instance runs an entire campaign from a single `start` pulse.

---
 rtl/fault_pkg.sv | 22 ++
 rtl/fault_cnt_seq.sv | 56 +++++
 rtl/fault_campaign_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fault_campaign_ctrl.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared types and helpers for the fault-injection campaign controller.
// The one-hot helper is sized generously; callers truncate it to their own bus width.
package fault_pkg;

  localparam int MAX_NG = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_REPORT,
    ST_DONE
  } state_t;

  function automatic logic [MAX_NG-1:0] onehot_gid(input int unsigned gid);
    logic [MAX_NG-1:0] v;
    v = '0;
    v[0] = 1'b1;
    return v << gid;
  endfunction

endpackage

// File: rtl/fault_cnt_seq.sv
// Campaign position counters: gate ID (major), stuck value (minor) and vector index.
// The controller FSM decides when to clear, step the vector or advance the fault configuration.
module fault_cnt_seq
  import fault_pkg::*;
#(
  parameter int NG_USED = 128,
  parameter int NVEC    = 512,
  parameter int GW      = 7,
  parameter int VW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_vec_inc,
  input  logic          i_cfg_adv,
  output logic [GW-1:0] o_gid,
  output logic          o_fv,
  output logic [VW-1:0] o_vec_idx,
  output logic          o_vec_last,
  output logic          o_cfg_last
);

  logic [GW-1:0] r_gid;
  logic          r_fv;
  logic [VW-1:0] r_vec_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gid     <= '0;
      r_fv      <= 1'b0;
      r_vec_idx <= '0;
    end else if (i_clr) begin
      r_gid     <= '0;
      r_fv      <= 1'b0;
      r_vec_idx <= '0;
    end else if (i_cfg_adv) begin
      // fv is the minor index: 0 -> 1 within a gate, then the next gate at fv = 0
      r_vec_idx <= '0;
      if (r_fv) begin
        r_fv  <= 1'b0;
        r_gid <= r_gid + 1'b1;
      end else begin
        r_fv <= 1'b1;
      end
    end else if (i_vec_inc) begin
      r_vec_idx <= r_vec_idx + 1'b1;
    end
  end

  assign o_gid      = r_gid;
  assign o_fv       = r_fv;
  assign o_vec_idx  = r_vec_idx;
  assign o_vec_last = (r_vec_idx == VW'(NVEC - 1));
  assign o_cfg_last = (r_gid == GW'(NG_USED - 1)) && r_fv;

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Runs a full stuck-at campaign over an external combinational adder and streams one
// mismatch count per (gate, stuck value) pair. All outputs are registered from next-state values.
module fault_campaign_ctrl
  import fault_pkg::*;
#(
  parameter  int NG      = 128,
  parameter  int NG_USED = 128,
  parameter  int W       = 4,
  parameter  int NVEC    = 2 ** (2 * W + 1),
  localparam int GW      = (NG > 1) ? $clog2(NG) : 1,
  localparam int VW      = 2 * W + 1,
  localparam int CW      = $clog2(NVEC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [NG-1:0] fault_en_bus,
  output logic          fault_val,
  output logic [W-1:0]  vec_a,
  output logic [W-1:0]  vec_b,
  output logic          vec_cin,
  input  logic [W-1:0]  dut_sum,
  input  logic          dut_cout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [GW-1:0] res_gid,
  output logic          res_val,
  output logic [CW-1:0] res_err_cnt
);

  state_t        r_state, w_state_next;
  logic [GW-1:0] w_gid;
  logic          w_fv;
  logic [VW-1:0] w_vec_idx;
  logic          w_vec_last, w_cfg_last;
  logic          w_hs, w_clr, w_vec_inc, w_cfg_adv;
  logic [W:0]    w_golden;
  logic          w_mismatch, w_active;
  logic [CW-1:0] r_err_cnt;

  logic          r_busy, w_busy_next;
  logic          r_done, w_done_next;
  logic [NG-1:0] r_fault_en, w_fault_en_next;
  logic          r_fault_val, w_fault_val_next;
  logic [W-1:0]  r_vec_a, w_vec_a_next;
  logic [W-1:0]  r_vec_b, w_vec_b_next;
  logic          r_vec_cin, w_vec_cin_next;
  logic          r_res_valid, w_res_valid_next;
  logic [GW-1:0] r_res_gid, w_res_gid_next;
  logic          r_res_val, w_res_val_next;
  logic [CW-1:0] r_res_err_cnt, w_res_err_cnt_next;

  assign w_hs      = r_res_valid && res_ready;
  assign w_clr     = (r_state == ST_IDLE) && start;
  assign w_vec_inc = (r_state == ST_CHECK) && !w_vec_last;
  assign w_cfg_adv = (r_state == ST_REPORT) && w_hs;

  fault_cnt_seq #(
    .NG_USED (NG_USED),
    .NVEC    (NVEC),
    .GW      (GW),
    .VW      (VW)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_vec_inc  (w_vec_inc),
    .i_cfg_adv  (w_cfg_adv),
    .o_gid      (w_gid),
    .o_fv       (w_fv),
    .o_vec_idx  (w_vec_idx),
    .o_vec_last (w_vec_last),
    .o_cfg_last (w_cfg_last)
  );

  assign w_golden   = (W + 1)'(r_vec_a) + (W + 1)'(r_vec_b) + (W + 1)'(r_vec_cin);
  assign w_mismatch = ({dut_cout, dut_sum} != w_golden);

  // Fault stays on across CHECK->APPLY for the same config; it rises one cycle late after REPORT
  assign w_active = (w_state_next == ST_CHECK) ||
                    ((r_state == ST_CHECK) && (w_state_next == ST_APPLY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fault_en    <= '0;
      r_fault_val   <= 1'b0;
      r_vec_a       <= '0;
      r_vec_b       <= '0;
      r_vec_cin     <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_gid     <= '0;
      r_res_val     <= 1'b0;
      r_res_err_cnt <= '0;
    end else begin
      r_state       <= w_state_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_fault_en    <= w_fault_en_next;
      r_fault_val   <= w_fault_val_next;
      r_vec_a       <= w_vec_a_next;
      r_vec_b       <= w_vec_b_next;
      r_vec_cin     <= w_vec_cin_next;
      r_res_valid   <= w_res_valid_next;
      r_res_gid     <= w_res_gid_next;
      r_res_val     <= w_res_val_next;
      r_res_err_cnt <= w_res_err_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_clr || w_cfg_adv) begin
      r_err_cnt <= '0;
    end else if ((r_state == ST_CHECK) && w_mismatch) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_APPLY;
      ST_APPLY:  w_state_next = ST_CHECK;
      ST_CHECK:  w_state_next = w_vec_last ? ST_REPORT : ST_APPLY;
      ST_REPORT: if (w_hs) w_state_next = w_cfg_last ? ST_DONE : ST_APPLY;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy_next        = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
    w_done_next        = (w_state_next == ST_DONE);
    w_fault_en_next    = w_active ? NG'(onehot_gid(32'(w_gid))) : '0;
    w_fault_val_next   = w_active ? w_fv : 1'b0;
    w_vec_a_next       = r_vec_a;
    w_vec_b_next       = r_vec_b;
    w_vec_cin_next     = r_vec_cin;
    w_res_valid_next   = r_res_valid;
    w_res_gid_next     = r_res_gid;
    w_res_val_next     = r_res_val;
    w_res_err_cnt_next = r_res_err_cnt;
    if (r_state == ST_APPLY) begin
      {w_vec_cin_next, w_vec_b_next, w_vec_a_next} = w_vec_idx;
    end else if ((w_state_next == ST_DONE) || (w_state_next == ST_IDLE)) begin
      w_vec_a_next   = '0;
      w_vec_b_next   = '0;
      w_vec_cin_next = 1'b0;
    end
    if ((r_state == ST_CHECK) && (w_state_next == ST_REPORT)) begin
      w_res_valid_next   = 1'b1;
      w_res_gid_next     = w_gid;
      w_res_val_next     = w_fv;
      w_res_err_cnt_next = r_err_cnt + CW'(w_mismatch);
    end else if (w_cfg_adv) begin
      w_res_valid_next   = 1'b0;
      w_res_gid_next     = '0;
      w_res_val_next     = 1'b0;
      w_res_err_cnt_next = '0;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign fault_en_bus = r_fault_en;
  assign fault_val    = r_fault_val;
  assign vec_a        = r_vec_a;
  assign vec_b        = r_vec_b;
  assign vec_cin      = r_vec_cin;
  assign res_valid    = r_res_valid;
  assign res_gid      = r_res_gid;
  assign res_val      = r_res_val;
  assign res_err_cnt  = r_res_err_cnt;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: a configurable stub adder with one injectable fault,
// and an arithmetic model of how many operand vectors each fault configuration corrupts.
module tb_fault_campaign_ctrl;

  localparam int NG       = 4;
  localparam int NG_USED  = 4;
  localparam int W        = 2;
  localparam int NVEC     = 32;
  localparam int GW       = 2;
  localparam int CW       = 6;
  localparam int NRES     = 2 * NG_USED;
  localparam int CAMP_CYC = 2 * NG_USED * (2 * NVEC + 1) + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          res_ready = 1'b1;
  logic          busy, done, fault_val, vec_cin, res_valid, res_val, dut_cout;
  logic [NG-1:0] fault_en_bus;
  logic [W-1:0]  vec_a, vec_b, dut_sum;
  logic [GW-1:0] res_gid;
  logic [CW-1:0] res_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Stub fault: kind 0 none, 1 invert sum[0], 2 force cout=0, 3 force cout=1
  int skind = 0;
  int sgate = 0;
  int ssv   = 0;
  logic [2:0] tsum;

  typedef struct {
    int gid;
    int val;
    int cnt;
  } res_t;
  res_t q[$];
  res_t mon_r;

  fault_campaign_ctrl #(
    .NG      (NG),
    .NG_USED (NG_USED),
    .W       (W),
    .NVEC    (NVEC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fault_en_bus (fault_en_bus),
    .fault_val    (fault_val),
    .vec_a        (vec_a),
    .vec_b        (vec_b),
    .vec_cin      (vec_cin),
    .dut_sum      (dut_sum),
    .dut_cout     (dut_cout),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_gid      (res_gid),
    .res_val      (res_val),
    .res_err_cnt  (res_err_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    tsum = 3'(vec_a) + 3'(vec_b) + 3'(vec_cin);
    if (fault_en_bus[sgate[1:0]] && (fault_val == ssv[0])) begin
      case (skind)
        1:       tsum[0] = ~tsum[0];
        2:       tsum[2] = 1'b0;
        3:       tsum[2] = 1'b1;
        default: ;
      endcase
    end
    dut_sum  = tsum[1:0];
    dut_cout = tsum[2];
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      mon_r.gid = int'(res_gid);
      mon_r.val = int'(res_val);
      mon_r.cnt = int'(res_err_cnt);
      q.push_back(mon_r);
      $display("[TB] result gid=%0d val=%0d err_cnt=%0d", mon_r.gid, mon_r.val, mon_r.cnt);
    end
  end

  // Expected mismatch count from the arithmetic of the injected fault over every operand vector
  function automatic int model_cnt(input int g, input int v);
    int n;
    int a, b, c, good, bad;
    n = 0;
    if (skind == 0 || g != sgate || v != ssv) return 0;
    for (int idx = 0; idx < NVEC; idx++) begin
      a    = idx % (1 << W);
      b    = (idx >> W) % (1 << W);
      c    = (idx >> (2 * W)) & 1;
      good = a + b + c;
      case (skind)
        1:       bad = good ^ 1;
        2:       bad = good % (1 << W);
        3:       bad = good | (1 << W);
        default: bad = good;
      endcase
      if (bad != good) n++;
    end
    return n;
  endfunction

  task automatic wait_done(input int ready_mode, input bit stray, inout int cycles, output bit to);
    to = 1'b0;
    while (done !== 1'b1) begin
      if (cycles > 4 * CAMP_CYC + 2000) begin
        to = 1'b1;
        break;
      end
      if (ready_mode == 1) res_ready = ($urandom_range(0, 3) != 0);
      start = stray && ((cycles % 37) == 5);
      @(posedge clk);
      #1;
      cycles++;
    end
    start     = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic run_campaign(input int ready_mode, input bit stray, output int cycles, output bit to);
    q.delete();
    start  = 1'b1;
    cycles = 1;
    @(posedge clk);
    #1;
    cycles++;
    start = 1'b0;
    wait_done(ready_mode, stray, cycles, to);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, res_valid, fault_val, vec_cin, res_val} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, res_valid, fault_val, vec_cin, res_val});
    end
    n_tests++;
    if (fault_en_bus !== '0) begin
      n_fail++;
      $display("FAIL reset_fault_en: got %b want 0", fault_en_bus);
    end
    n_tests++;
    if ({vec_a, vec_b, res_gid, res_err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_vec_res: got a=%0d b=%0d gid=%0d cnt=%0d want all 0", vec_a, vec_b, res_gid, res_err_cnt);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b res_valid=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_fault_free();
    int  cycles;
    bit  to;
    skind = 0;
    q.delete();
    start  = 1'b1;
    cycles = 1;
    @(posedge clk);
    #1;
    cycles++;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    wait_done(0, 1'b0, cycles, to);
    n_tests++;
    if (to || cycles != CAMP_CYC) begin
      n_fail++;
      $display("FAIL done_latency: got %0d cycles (timeout=%0b) want %0d", cycles, to, CAMP_CYC);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
    n_tests++;
    if (q.size() != NRES) begin
      n_fail++;
      $display("FAIL ff_count: got %0d results want %0d", q.size(), NRES);
    end
    for (int i = 0; i < q.size() && i < NRES; i++) begin
      n_tests++;
      if (q[i].gid != i / 2 || q[i].val != i % 2 || q[i].cnt != 0) begin
        n_fail++;
        $display("FAIL ff_result[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,0)", i, q[i].gid, q[i].val, q[i].cnt, i / 2, i % 2);
      end
    end
  endtask

  task automatic test_inv_sum();
    int cycles;
    bit to;
    skind = 1; sgate = 1; ssv = 1;
    run_campaign(0, 1'b0, cycles, to);
    n_tests++;
    if (to || q.size() != NRES) begin
      n_fail++;
      $display("FAIL inv_count: got %0d results (timeout=%0b) want %0d", q.size(), to, NRES);
    end
    n_tests++;
    if (q.size() > 3 && q[3].cnt != NVEC) begin
      n_fail++;
      $display("FAIL inv_target: got %0d want %0d", q[3].cnt, NVEC);
    end
    for (int i = 0; i < q.size() && i < NRES; i++) begin
      n_tests++;
      if (q[i].gid != i / 2 || q[i].val != i % 2 || q[i].cnt != model_cnt(i / 2, i % 2)) begin
        n_fail++;
        $display("FAIL inv_result[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, q[i].gid, q[i].val, q[i].cnt, i / 2, i % 2, model_cnt(i / 2, i % 2));
      end
    end
  endtask

  task automatic test_cout_stuck();
    int cycles;
    bit to;
    skind = 2; sgate = 2; ssv = 0;
    run_campaign(0, 1'b0, cycles, to);
    n_tests++;
    if (to || q.size() != NRES) begin
      n_fail++;
      $display("FAIL cout_count: got %0d results (timeout=%0b) want %0d", q.size(), to, NRES);
    end
    for (int i = 0; i < q.size() && i < NRES; i++) begin
      n_tests++;
      if (q[i].gid != i / 2 || q[i].val != i % 2 || q[i].cnt != model_cnt(i / 2, i % 2)) begin
        n_fail++;
        $display("FAIL cout_result[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, q[i].gid, q[i].val, q[i].cnt, i / 2, i % 2, model_cnt(i / 2, i % 2));
      end
    end
  endtask

  task automatic test_backpressure();
    int         cycles, waited;
    bit         to;
    logic [GW-1:0] g0;
    logic       v0;
    logic [CW-1:0] c0;
    logic [2*W:0]  vec0;
    skind = 1; sgate = 0; ssv = 0;
    q.delete();
    res_ready = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    waited = 0;
    while (res_valid !== 1'b1 && waited < 4 * NVEC) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_tests++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_valid: res_valid=%b after %0d cycles want 1", res_valid, waited);
    end
    g0 = res_gid; v0 = res_val; c0 = res_err_cnt; vec0 = {vec_cin, vec_b, vec_a};
    n_tests++;
    if (int'(g0) != 0 || v0 !== 1'b0 || int'(c0) != model_cnt(0, 0)) begin
      n_fail++;
      $display("FAIL bp_first_fields: got (%0d,%0d,%0d) want (0,0,%0d)", g0, v0, c0, model_cnt(0, 0));
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (res_valid !== 1'b1 || res_gid !== g0 || res_val !== v0 || res_err_cnt !== c0 ||
          fault_en_bus !== '0 || {vec_cin, vec_b, vec_a} !== vec0) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: valid=%b gid=%0d val=%0d cnt=%0d fen=%b vec=%0d want 1,%0d,%0d,%0d,0,%0d",
                 k, res_valid, res_gid, res_val, res_err_cnt, fault_en_bus, {vec_cin, vec_b, vec_a}, g0, v0, c0, vec0);
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_no_handshake: got %0d results want 0", q.size());
    end
    res_ready = 1'b1;
    cycles    = 0;
    wait_done(0, 1'b0, cycles, to);
    @(posedge clk);
    #1;
    n_tests++;
    if (to || q.size() != NRES) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results (timeout=%0b) want %0d", q.size(), to, NRES);
    end
    for (int i = 0; i < q.size() && i < NRES; i++) begin
      n_tests++;
      if (q[i].gid != i / 2 || q[i].val != i % 2 || q[i].cnt != model_cnt(i / 2, i % 2)) begin
        n_fail++;
        $display("FAIL bp_result[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, q[i].gid, q[i].val, q[i].cnt, i / 2, i % 2, model_cnt(i / 2, i % 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cycles, waited;
    bit to;
    skind = 1; sgate = 2; ssv = 0;
    q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    waited = 0;
    while (fault_en_bus !== 4'b0100 && waited < CAMP_CYC) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_tests++;
    if (fault_en_bus !== 4'b0100) begin
      n_fail++;
      $display("FAIL rm_reach_gid2: fen=%b want 0100", fault_en_bus);
    end
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, res_valid, fault_val, vec_cin, res_val} !== 6'b0 || fault_en_bus !== '0 ||
        {vec_a, vec_b, res_gid, res_err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rm_async_clear: busy=%b done=%b valid=%b fv=%b fen=%b a=%0d b=%0d cin=%b gid=%0d cnt=%0d want all 0",
               busy, done, res_valid, fault_val, fault_en_bus, vec_a, vec_b, vec_cin, res_gid, res_err_cnt);
    end
    n_tests++;
    if (q.size() != 4) begin
      n_fail++;
      $display("FAIL rm_partial: got %0d results before reset want 4", q.size());
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (q.size() != 4 || res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_quiet: results=%0d valid=%b busy=%b want 4 0 0", q.size(), res_valid, busy);
    end
    run_campaign(0, 1'b0, cycles, to);
    n_tests++;
    if (to || q.size() != NRES || cycles != CAMP_CYC) begin
      n_fail++;
      $display("FAIL rm_restart: results=%0d cycles=%0d timeout=%0b want %0d %0d 0", q.size(), cycles, to, NRES, CAMP_CYC);
    end
    for (int i = 0; i < q.size() && i < NRES; i++) begin
      n_tests++;
      if (q[i].gid != i / 2 || q[i].val != i % 2 || q[i].cnt != model_cnt(i / 2, i % 2)) begin
        n_fail++;
        $display("FAIL rm_result[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, q[i].gid, q[i].val, q[i].cnt, i / 2, i % 2, model_cnt(i / 2, i % 2));
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cycles;
    bit to;
    skind = 3; sgate = 3; ssv = 1;
    run_campaign(0, 1'b1, cycles, to);
    n_tests++;
    if (to || cycles != CAMP_CYC) begin
      n_fail++;
      $display("FAIL swb_latency: got %0d cycles (timeout=%0b) want %0d", cycles, to, CAMP_CYC);
    end
    n_tests++;
    if (q.size() != NRES) begin
      n_fail++;
      $display("FAIL swb_count: got %0d results want %0d", q.size(), NRES);
    end
    for (int i = 0; i < q.size() && i < NRES; i++) begin
      n_tests++;
      if (q[i].gid != i / 2 || q[i].val != i % 2 || q[i].cnt != model_cnt(i / 2, i % 2)) begin
        n_fail++;
        $display("FAIL swb_result[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, q[i].gid, q[i].val, q[i].cnt, i / 2, i % 2, model_cnt(i / 2, i % 2));
      end
    end
  endtask

  task automatic test_random();
    int cycles;
    bit to;
    for (int it = 0; it < 4; it++) begin
      skind = int'($urandom_range(0, 3));
      sgate = int'($urandom_range(0, NG_USED - 1));
      ssv   = int'($urandom_range(0, 1));
      run_campaign(1, 1'b0, cycles, to);
      n_tests++;
      if (to || q.size() != NRES) begin
        n_fail++;
        $display("FAIL rnd%0d_count: got %0d results (timeout=%0b) want %0d", it, q.size(), to, NRES);
      end
      for (int i = 0; i < q.size() && i < NRES; i++) begin
        n_tests++;
        if (q[i].gid != i / 2 || q[i].val != i % 2 || q[i].cnt != model_cnt(i / 2, i % 2)) begin
          n_fail++;
          $display("FAIL rnd%0d_result[%0d]: kind=%0d gate=%0d sv=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   it, i, skind, sgate, ssv, q[i].gid, q[i].val, q[i].cnt, i / 2, i % 2, model_cnt(i / 2, i % 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_inv_sum();
    test_cout_stuck();
    test_backpressure();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
